// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the az_bus interconnect arbiter.
//   BUS_ADDR_W  : word address width on master and slave sides
//   BUS_DATA_W  : data width on master and slave sides
//   arb_state_t : arbiter FSM state encoding (IDLE / BUSY)
//   rr_wrap_inc : index + 1 with wrap to 0 at n (round-robin pointer advance)
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Next round-robin index after idx in a ring of n entries.
  function automatic int rr_wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 32'sd1;
    if (nxt >= n) begin
      nxt = 32'sd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the az_bus master-side request/response signals and the shared
// slave-side bus.
//   m_req/m_addr/m_wr/m_wdata : per-master request, address, write flag, data
//   m_ack/m_err/m_rdata       : completion strobe, timeout error, read data
//   s_valid/s_addr/s_wr/s_wdata : granted transfer on the slave-side bus
//   s_ready/s_rdata           : slave completion and read data
// Modports:
//   arb    : the arbiter itself
//   master : the requesting masters
//   slave  : the slave / address decoder side
// -----------------------------------------------------------------------------
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 4
);

  logic [N_MASTERS-1:0]                 m_req;
  logic [N_MASTERS-1:0][BUS_ADDR_W-1:0] m_addr;
  logic [N_MASTERS-1:0]                 m_wr;
  logic [N_MASTERS-1:0][BUS_DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]                 m_ack;
  logic [N_MASTERS-1:0]                 m_err;
  logic [BUS_DATA_W-1:0]                m_rdata;

  logic                                 s_valid;
  logic [BUS_ADDR_W-1:0]                s_addr;
  logic                                 s_wr;
  logic [BUS_DATA_W-1:0]                s_wdata;
  logic                                 s_ready;
  logic [BUS_DATA_W-1:0]                s_rdata;

  modport arb (
    input  m_req, m_addr, m_wr, m_wdata, s_ready, s_rdata,
    output m_ack, m_err, m_rdata, s_valid, s_addr, s_wr, s_wdata
  );

  modport master (
    output m_req, m_addr, m_wr, m_wdata,
    input  m_ack, m_err, m_rdata
  );

  modport slave (
    input  s_valid, s_addr, s_wr, s_wdata,
    output s_ready, s_rdata
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin selector: returns the first requesting
// index at or above ptr, scanning modulo N_MASTERS.
//   req     (in)  : request vector
//   ptr     (in)  : index with highest priority this round
//   gnt_idx (out) : selected index (0 when nothing requests)
//   gnt_any (out) : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_any
);

  int               w_sum;
  logic [IDX_W-1:0] w_cand;
  logic             w_hit;

  // Scan from ptr upwards with wrap; the first hit wins and later hits are ignored.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_sum   = 32'sd0;
    w_cand  = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      w_sum   = int'(ptr) + k;
      w_cand  = (w_sum >= N_MASTERS) ? IDX_W'(w_sum - N_MASTERS) : IDX_W'(w_sum);
      w_hit   = !gnt_any && req[w_cand];
      gnt_idx = w_hit ? w_cand : gnt_idx;
      gnt_any = gnt_any | req[w_cand];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the az_bus interconnect. One single-beat transfer is
// in flight at a time: an IDLE cycle registers the round-robin winner, then the
// BUSY state drives the winner's request onto the slave bus until s_ready.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : bus_arbiter_if.arb (master request/response + shared slave bus)
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   defined   : a BUSY transfer without s_ready for TIMEOUT cycles is aborted
//               with m_err + m_ack to the granted master
//   undefined : no counter, m_err tied to 0, BUSY waits indefinitely
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic      clk,
  input  logic      rst,
  bus_arbiter_if.arb bus
);

  localparam int IDX_W = $clog2(N_MASTERS);

  if ((N_MASTERS < 2) || (N_MASTERS > 8)) begin : g_n_masters_check
    $error("bus_arbiter: N_MASTERS must be in 2..8");
  end
  if (TIMEOUT < 2) begin : g_timeout_check
    $error("bus_arbiter: TIMEOUT must be >= 2");
  end

  arb_state_t            r_state;
  logic [IDX_W-1:0]      r_grant;
  logic [IDX_W-1:0]      r_ptr;
  logic                  r_mask_vld;   // last-acked master is masked for one IDLE cycle

  logic [N_MASTERS-1:0]  w_mask;
  logic [N_MASTERS-1:0]  w_req_masked;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_any;
  logic                  w_timeout;
  logic                  w_done;

  // Mask the master that just completed: its m_req is still high on the
  // cycle after its ack and must not win a second transfer.
  always_comb begin
    w_mask = '0;
    if (r_mask_vld) begin
      w_mask[r_grant] = 1'b1;
    end else begin
      w_mask = '0;
    end
    w_req_masked = bus.m_req & ~w_mask;
  end

  rr_pick #(
    .N_MASTERS (N_MASTERS),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req     (w_req_masked),
    .ptr     (r_ptr),
    .gnt_idx (w_pick_idx),
    .gnt_any (w_pick_any)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Wait-cycle counter: held at 0 in IDLE so it starts from 0 on BUSY entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != ARB_BUSY) begin
      r_cnt <= '0;
    end else if (!bus.s_ready) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Abort only when the slave is still silent; s_ready in the same cycle wins.
  always_comb begin
    if ((r_state == ARB_BUSY) && !bus.s_ready && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
      w_timeout = 1'b1;
    end else begin
      w_timeout = 1'b0;
    end
  end
`else
  // Timeout feature not built: BUSY is only left on s_ready.
  always_comb begin
    w_timeout = 1'b0;
  end
`endif

  // A transfer ends on slave completion or on timeout abort.
  always_comb begin
    if (r_state == ARB_BUSY) begin
      w_done = bus.s_ready | w_timeout;
    end else begin
      w_done = 1'b0;
    end
  end

  // Arbitration FSM: register the pick in IDLE, release in BUSY on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_mask_vld <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_mask_vld <= 1'b0;
          if (w_pick_any) begin
            r_grant <= w_pick_idx;
            r_state <= ARB_BUSY;
          end else begin
            r_grant <= r_grant;
            r_state <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          if (w_done) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= IDX_W'(rr_wrap_inc(int'(r_grant), N_MASTERS));
            r_mask_vld <= 1'b1;
          end else begin
            r_state    <= ARB_BUSY;
            r_mask_vld <= 1'b0;
          end
        end
        default: begin
          r_state    <= ARB_IDLE;
          r_mask_vld <= 1'b0;
        end
      endcase
    end
  end

  // Slave-bus mux and response steering; everything is quiet outside BUSY.
  always_comb begin
    bus.s_valid = 1'b0;
    bus.s_addr  = '0;
    bus.s_wr    = 1'b0;
    bus.s_wdata = '0;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    bus.m_rdata = '0;
    if (r_state == ARB_BUSY) begin
      bus.s_valid          = 1'b1;
      bus.s_addr           = bus.m_addr[r_grant];
      bus.s_wr             = bus.m_wr[r_grant];
      bus.s_wdata          = bus.m_wdata[r_grant];
      bus.m_ack[r_grant]   = w_done;
      bus.m_err[r_grant]   = w_timeout;
      bus.m_rdata          = w_timeout ? '0 : bus.s_rdata;
    end else begin
      bus.s_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter: a transaction-level model checks every
// cycle, directed scenarios pin literal expectations, then randomized masters
// and slave exercise the arbiter against the model.
// Build with BUS_ARB_TIMEOUT_EN defined to cover the timeout feature.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int TO = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_arbiter_if #(.N_MASTERS(N)) bus ();

  bus_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.arb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit              md_busy  = 1'b0;
  int              md_grant = 0;
  int              md_ptr   = 0;
  int              md_mask  = -1;   // master excluded from the next pick
  int              md_wait  = 0;    // BUSY cycles already spent without s_ready
  logic [N-1:0]    obs_ack  = '0;

  initial begin : compare
    logic [N-1:0]  e_ack, e_err;
    logic [31:0]   e_rdata, e_wdata;
    logic [29:0]   e_addr;
    logic          e_valid, e_wr, to_hit, done;
    int            idx;
    bit            found;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_ack = '0; e_err = '0; e_rdata = 32'd0; e_wdata = 32'd0;
      e_addr = 30'd0; e_valid = 1'b0; e_wr = 1'b0; to_hit = 1'b0; done = 1'b0;
      if (md_busy) begin
        to_hit  = TO_EN && !bus.s_ready && (md_wait == TO - 1);
        done    = bus.s_ready || to_hit;
        e_valid = 1'b1;
        e_addr  = bus.m_addr[md_grant[IW-1:0]];
        e_wr    = bus.m_wr[md_grant[IW-1:0]];
        e_wdata = bus.m_wdata[md_grant[IW-1:0]];
        e_ack[md_grant[IW-1:0]] = done;
        e_err[md_grant[IW-1:0]] = to_hit;
        e_rdata = to_hit ? 32'd0 : bus.s_rdata;
      end
      check("s_valid", {63'd0, bus.s_valid}, {63'd0, e_valid});
      check("s_addr",  {34'd0, bus.s_addr},  {34'd0, e_addr});
      check("s_wr",    {63'd0, bus.s_wr},    {63'd0, e_wr});
      check("s_wdata", {32'd0, bus.s_wdata}, {32'd0, e_wdata});
      check("m_ack",   {60'd0, bus.m_ack},   {60'd0, e_ack});
      check("m_err",   {60'd0, bus.m_err},   {60'd0, e_err});
      check("m_rdata", {32'd0, bus.m_rdata}, {32'd0, e_rdata});
      obs_ack = bus.m_ack;
      // state at the coming edge
      if (rst) begin
        md_busy = 1'b0; md_grant = 0; md_ptr = 0; md_mask = -1; md_wait = 0;
      end else if (md_busy) begin
        if (done) begin
          md_busy = 1'b0;
          md_ptr  = (md_grant + 1) % N;
          md_mask = md_grant;
        end else begin
          md_wait++;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (md_ptr + k) % N;
          if (!found && bus.m_req[idx[IW-1:0]] && (idx != md_mask)) begin
            found    = 1'b1;
            md_grant = idx;
          end
        end
        if (found) begin
          md_busy = 1'b1;
          md_wait = 0;
        end
        md_mask = -1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int m, input logic wr, input logic [29:0] a, input logic [31:0] d);
    bus.m_req[m]   = 1'b1;
    bus.m_wr[m]    = wr;
    bus.m_addr[m]  = a;
    bus.m_wdata[m] = d;
  endtask

  int           rr_order [5] = '{0, 1, 2, 3, 0};
  int           rdy_pct;
  logic [N-1:0] one_hot;

  initial begin : main
    bus.m_req = '0; bus.m_wr = '0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.s_ready = 1'b0; bus.s_rdata = 32'd0;
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_s_valid", {63'd0, bus.s_valid}, 64'd0);
    check("rst_m_ack",   {60'd0, bus.m_ack},   64'd0);
    check("rst_m_err",   {60'd0, bus.m_err},   64'd0);
    check("rst_m_rdata", {32'd0, bus.m_rdata}, 64'd0);

    // single master write, slave stalls two cycles
    tick(); rst = 1'b0;
    drive_req(1, 1'b1, 30'h0800_0010, 32'hDEAD_BEEF);
    @(negedge clk); check("t1_arb_valid", {63'd0, bus.s_valid}, 64'd0);
    tick();
    @(negedge clk);
    check("t1_valid", {63'd0, bus.s_valid}, 64'd1);
    check("t1_addr",  {34'd0, bus.s_addr},  64'h0800_0010);
    check("t1_wr",    {63'd0, bus.s_wr},    64'd1);
    check("t1_wdata", {32'd0, bus.s_wdata}, 64'hDEAD_BEEF);
    check("t1_ack_w1", {60'd0, bus.m_ack},  64'd0);
    tick(); @(negedge clk); check("t1_ack_w2", {60'd0, bus.m_ack}, 64'd0);
    tick(); bus.s_ready = 1'b1;
    @(negedge clk); check("t1_ack", {60'd0, bus.m_ack}, 64'h2);
    tick(); bus.m_req[1] = 1'b0; bus.s_ready = 1'b0;
    @(negedge clk);
    check("t1_after_valid", {63'd0, bus.s_valid}, 64'd0);

    // round robin from ptr=0 with all masters requesting and s_ready high
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int m = 0; m < N; m++) drive_req(m, m[0], 30'(32'h100 * (m + 1)), 32'(m));
    bus.s_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rr_valid", {63'd0, bus.s_valid}, {63'd0, c[0]});
      if (c[0]) begin
        one_hot = '0;
        one_hot[rr_order[c / 2]] = 1'b1;
        check("rr_ack", {60'd0, bus.m_ack}, {60'd0, one_hot});
      end
      tick();
    end
    bus.m_req = '0; bus.s_ready = 1'b0;

    // read data returned to M2 with the ack
    drive_req(2, 1'b0, 30'h1000_0004, 32'd0);
    bus.s_rdata = 32'h1234_5678; bus.s_ready = 1'b1;
    @(negedge clk); check("rd_arb_valid", {63'd0, bus.s_valid}, 64'd0);
    tick(); @(negedge clk);
    check("rd_rdata", {32'd0, bus.m_rdata}, 64'h1234_5678);
    check("rd_ack",   {60'd0, bus.m_ack},   64'h4);
    check("rd_wr",    {63'd0, bus.s_wr},    64'd0);
    tick(); bus.m_req[2] = 1'b0; bus.s_ready = 1'b0; bus.s_rdata = 32'd0;

    // reset mid-transfer, then M3 and M0 compete (ptr was 3 before reset)
    drive_req(1, 1'b1, 30'h0000_0111, 32'h1111_1111);
    tick(); @(negedge clk); check("rs_busy_valid", {63'd0, bus.s_valid}, 64'd1);
    tick(); rst = 1'b1; bus.m_req[1] = 1'b0;
    @(negedge clk); check("rs_rst_ack", {60'd0, bus.m_ack}, 64'd0);
    tick(); rst = 1'b0;
    drive_req(3, 1'b0, 30'h0000_0333, 32'd3);
    drive_req(0, 1'b1, 30'h0000_0AAA, 32'd0);
    @(negedge clk);
    check("rs_valid_drop", {63'd0, bus.s_valid}, 64'd0);
    check("rs_ack_drop",   {60'd0, bus.m_ack},   64'd0);
    tick(); bus.s_ready = 1'b1;
    @(negedge clk);
    check("rs_first_addr", {34'd0, bus.s_addr}, 64'h0AAA);
    check("rs_first_ack",  {60'd0, bus.m_ack},  64'h1);
    tick(); bus.m_req[0] = 1'b0;
    @(negedge clk); check("rs_gap_valid", {63'd0, bus.s_valid}, 64'd0);
    tick(); @(negedge clk); check("rs_second_ack", {60'd0, bus.m_ack}, 64'h8);
    tick(); bus.m_req[3] = 1'b0; bus.s_ready = 1'b0;

`ifdef BUS_ARB_TIMEOUT_EN
    // slave never answers: abort on the 4th BUSY cycle with zeroed read data
    drive_req(0, 1'b0, 30'h0000_0040, 32'd0);
    bus.s_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      tick(); @(negedge clk);
      check("to_err", {60'd0, bus.m_err}, (i == 4) ? 64'h1 : 64'h0);
      check("to_ack", {60'd0, bus.m_ack}, (i == 4) ? 64'h1 : 64'h0);
      if (i == 4) check("to_rdata", {32'd0, bus.m_rdata}, 64'd0);
    end
    tick(); bus.m_req[0] = 1'b0;
    tick(); drive_req(0, 1'b0, 30'h0000_0040, 32'd0);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) bus.s_ready = 1'b1;
      @(negedge clk);
      check("to_race_err", {60'd0, bus.m_err}, 64'h0);
      check("to_race_ack", {60'd0, bus.m_ack}, (i == 4) ? 64'h1 : 64'h0);
      if (i == 4) check("to_race_rdata", {32'd0, bus.m_rdata}, 64'hA5A5_A5A5);
    end
    tick(); bus.m_req[0] = 1'b0; bus.s_ready = 1'b0; bus.s_rdata = 32'd0;
`else
    // no timeout logic: BUSY holds for 200 stalled cycles
    drive_req(0, 1'b1, 30'h0000_0050, 32'h0BAD_F00D);
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      tick(); @(negedge clk);
      check("hold", {61'd0, bus.s_valid, |bus.m_err, |bus.m_ack}, 64'h4);
    end
    tick(); bus.s_ready = 1'b1;
    @(negedge clk);
    check("hold_end_ack", {60'd0, bus.m_ack}, 64'h1);
    check("hold_end_err", {60'd0, bus.m_err}, 64'h0);
    tick(); bus.m_req[0] = 1'b0; bus.s_ready = 1'b0;
`endif

    // randomized masters and slave, checked every cycle by the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rdy_pct = ((cyc / 500) % 2 == 0) ? 70 : 15;
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        bus.m_req = '0;
      end else begin
        rst = 1'b0;
        for (int m = 0; m < N; m++) begin
          if (obs_ack[m]) begin
            bus.m_req[m] = 1'b0;
          end else if (!bus.m_req[m] && ($urandom_range(3) == 0)) begin
            drive_req(m, 1'($urandom), 30'($urandom), $urandom);
          end
        end
      end
      bus.s_ready = ($urandom_range(99) < rdy_pct);
      bus.s_rdata = $urandom;
      tick();
    end
    rst = 1'b0; bus.m_req = '0; bus.s_ready = 1'b0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
